// File: rtl/dma_priority_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dma_priority_arbiter_if
//  Description : Bus bundle for the DMA priority arbiter. It carries the
//                command word, the channel request and mask vectors, the
//                HRQ/HLDA hold handshake, EOP, DACK, and the grant status and
//                strobes.
//                master : arbiter side (drives HRQ, DACK, status, strobes)
//                slave  : CPU / channel / datapath side (drives the inputs)
//  Revision    : 1.0  initial release
// ============================================================================
interface dma_priority_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
);
  logic [7:0]        command;
  logic [NUM_CH-1:0] DREQ;
  logic [NUM_CH-1:0] mask;
  logic              HLDA;
  logic              EOP;
  logic              HRQ;
  logic [NUM_CH-1:0] DACK;
  logic [CH_W-1:0]   active_ch;
  logic              busy;
  logic              service_start;
  logic              service_end;

  modport master (
    input  command, DREQ, mask, HLDA, EOP,
    output HRQ, DACK, active_ch, busy, service_start, service_end
  );

  modport slave (
    output command, DREQ, mask, HLDA, EOP,
    input  HRQ, DACK, active_ch, busy, service_start, service_end
  );
endinterface
`default_nettype wire

// File: rtl/dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dma_priority_arbiter
//  Description : Selects the DMA channel that owns the system bus (fixed or
//                rotating priority) and runs the HRQ/HLDA hold handshake.
//                Ports:
//                  clk   - system clock, all state changes on posedge
//                  RESET - asynchronous active-high reset
//                  bus   - dma_priority_arbiter_if.master: command, DREQ,
//                          mask, HLDA, EOP in; HRQ, DACK, active_ch, busy,
//                          service_start, service_end out
//  Revision    : 1.0  initial release
// ============================================================================
module dma_priority_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                   clk,
  input  logic                   RESET,
  dma_priority_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SERVICE = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   active_ch_q, active_ch_d;
  logic [CH_W-1:0]   last_ch_q, last_ch_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic              service_start_q, service_start_d;
  logic              service_end_q, service_end_d;

  logic [NUM_CH-1:0] qreq;
  logic              win_found;
  logic [CH_W-1:0]   win_idx;
  int                search_idx;
  logic              active_req;

  // Command bits that have no meaning for arbitration.
  logic unused_cmd_bits;
  assign unused_cmd_bits = &{bus.command[5], bus.command[3], bus.command[1:0]};

  // Requests normalised to active-high and filtered by the mask register.
  assign qreq       = (bus.command[6] ? bus.DREQ : ~bus.DREQ) & ~bus.mask;
  assign active_req = qreq[active_ch_q];

  // Winner search. Rotating mode starts one past the last serviced channel;
  // fixed mode starts at channel 0. The first hit in search order wins.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    search_idx = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.command[4]) begin
        search_idx = (int'(last_ch_q) + 1 + k) % NUM_CH;
      end else begin
        search_idx = k;
      end
      if (!win_found && qreq[search_idx]) begin
        win_found = 1'b1;
        win_idx   = CH_W'(search_idx);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    active_ch_d     = active_ch_q;
    last_ch_d       = last_ch_q;
    grant_d         = grant_q;
    service_start_d = 1'b0;
    service_end_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.command[2] && win_found) begin
          state_d     = ST_REQUEST;
          active_ch_d = win_idx;
        end
      end
      ST_REQUEST: begin
        // HLDA takes precedence over a simultaneous request drop.
        if (bus.HLDA) begin
          state_d         = ST_SERVICE;
          service_start_d = 1'b1;
          grant_d         = NUM_CH'(1) << active_ch_q;
        end else if (!active_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (!bus.HLDA || !bus.EOP || !active_req) begin
          // A revoked bus skips RELEASE since HLDA is already low.
          state_d       = bus.HLDA ? ST_RELEASE : ST_IDLE;
          service_end_d = 1'b1;
          last_ch_d     = active_ch_q;
          grant_d       = '0;
        end
      end
      ST_RELEASE: begin
        if (!bus.HLDA) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q         <= ST_IDLE;
      active_ch_q     <= '0;
      last_ch_q       <= CH_W'(NUM_CH - 1);
      grant_q         <= '0;
      service_start_q <= 1'b0;
      service_end_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      active_ch_q     <= active_ch_d;
      last_ch_q       <= last_ch_d;
      grant_q         <= grant_d;
      service_start_q <= service_start_d;
      service_end_q   <= service_end_d;
    end
  end

  // HRQ and busy decode straight from the state so reset clears them at once.
  assign bus.HRQ           = (state_q == ST_REQUEST) || (state_q == ST_SERVICE);
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.DACK          = bus.command[7] ? grant_q : ~grant_q;
  assign bus.active_ch     = active_ch_q;
  assign bus.service_start = service_start_q;
  assign bus.service_end   = service_end_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_priority_arbiter
//  Description : Directed self-checking bench for dma_priority_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dma_priority_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dma_priority_arbiter_if #(.NUM_CH(4), .CH_W(2)) bus ();

  dma_priority_arbiter #(.NUM_CH(4), .CH_W(2)) dut (
    .clk   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.HLDA = 1'b0;
    bus.EOP  = 1'b1;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
  endtask

  // One complete grant from IDLE with a request already pending:
  // arbitrate, HLDA, one service cycle ended by EOP, release, back to IDLE.
  task automatic serve(input string tag, input int ch);
    logic [3:0] oh;
    logic [3:0] dack_on;
    logic [3:0] dack_off;
    oh       = 4'(1 << ch);
    dack_on  = bus.command[7] ? oh : ~oh;
    dack_off = bus.command[7] ? 4'h0 : 4'hF;
    step();
    chk({tag, "_hrq"}, bus.HRQ, 1);
    chk({tag, "_ch"}, bus.active_ch, ch);
    chk({tag, "_dack_req"}, bus.DACK, dack_off);
    bus.HLDA = 1'b1;
    step();
    chk({tag, "_start"}, bus.service_start, 1);
    chk({tag, "_dack_svc"}, bus.DACK, dack_on);
    bus.EOP = 1'b0;
    step();
    chk({tag, "_end"}, bus.service_end, 1);
    chk({tag, "_hrq_rel"}, bus.HRQ, 0);
    chk({tag, "_dack_rel"}, bus.DACK, dack_off);
    bus.EOP  = 1'b1;
    bus.HLDA = 1'b0;
    step();
    chk({tag, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    // ---------------- reset values ----------------
    rst         = 1'b1;
    bus.command = 8'hC0;
    bus.DREQ    = 4'b0000;
    bus.mask    = 4'b0000;
    bus.HLDA    = 1'b0;
    bus.EOP     = 1'b1;
    #2;
    chk("rst_hrq", bus.HRQ, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ch", bus.active_ch, 0);
    chk("rst_dack", bus.DACK, 4'h0);
    chk("rst_start", bus.service_start, 0);
    chk("rst_end", bus.service_end, 0);
    step();
    step();
    rst = 1'b0;

    // ---------------- fixed priority, delayed HLDA ----------------
    bus.DREQ = 4'b1010;
    step();
    chk("fix_hrq", bus.HRQ, 1);
    chk("fix_ch", bus.active_ch, 1);
    chk("fix_dack_req", bus.DACK, 4'h0);
    step();
    step();
    chk("fix_wait_hrq", bus.HRQ, 1);
    chk("fix_wait_start", bus.service_start, 0);
    bus.HLDA = 1'b1;
    step();
    chk("fix_start", bus.service_start, 1);
    chk("fix_dack", bus.DACK, 4'b0010);
    step();
    chk("fix_start_pulse", bus.service_start, 0);
    chk("fix_dack_hold", bus.DACK, 4'b0010);
    bus.EOP  = 1'b0;
    bus.DREQ = 4'b1000;
    step();
    chk("fix_end", bus.service_end, 1);
    chk("fix_hrq_rel", bus.HRQ, 0);
    chk("fix_dack_rel", bus.DACK, 4'h0);
    bus.EOP = 1'b1;
    step();
    chk("fix_end_pulse", bus.service_end, 0);
    chk("fix_rel_hold", bus.busy, 1);
    bus.HLDA = 1'b0;
    step();
    chk("fix_idle", bus.busy, 0);
    step();
    chk("fix_ch3_hrq", bus.HRQ, 1);
    chk("fix_ch3", bus.active_ch, 3);
    bus.DREQ = 4'b0000;
    step();
    chk("fix_ch3_abort", bus.busy, 0);

    // ---------------- rotating priority ----------------
    do_reset();
    bus.command = 8'hD0;
    bus.DREQ    = 4'b1111;
    serve("rot0", 0);
    serve("rot1", 1);
    serve("rot2", 2);
    serve("rot3", 3);
    serve("rot4", 0);

    // ---------------- active-low polarity ----------------
    bus.command = 8'h00;
    bus.DREQ    = 4'b1111;
    do_reset();
    chk("pol_dack_idle", bus.DACK, 4'hF);
    bus.DREQ = 4'b1011;
    serve("pol", 2);

    // ---------------- abort in REQUEST ----------------
    bus.command = 8'hC0;
    bus.DREQ    = 4'b0000;
    do_reset();
    bus.DREQ = 4'b0001;
    step();
    chk("abt_hrq", bus.HRQ, 1);
    bus.DREQ = 4'b0000;
    step();
    chk("abt_hrq_drop", bus.HRQ, 0);
    chk("abt_busy", bus.busy, 0);
    chk("abt_start", bus.service_start, 0);
    chk("abt_end", bus.service_end, 0);

    // ---------------- masked request never raises HRQ ----------------
    bus.mask = 4'b0001;
    bus.DREQ = 4'b0001;
    step();
    chk("msk_hrq_a", bus.HRQ, 0);
    step();
    step();
    chk("msk_hrq_b", bus.HRQ, 0);
    chk("msk_busy", bus.busy, 0);

    // ---------------- mask applied during SERVICE ----------------
    bus.mask = 4'b0000;
    step();
    chk("msv_hrq", bus.HRQ, 1);
    bus.HLDA = 1'b1;
    step();
    chk("msv_dack", bus.DACK, 4'b0001);
    bus.mask = 4'b0001;
    step();
    chk("msv_end", bus.service_end, 1);
    chk("msv_hrq_rel", bus.HRQ, 0);
    chk("msv_release", bus.busy, 1);
    bus.HLDA = 1'b0;
    bus.mask = 4'b0000;
    step();
    chk("msv_idle", bus.busy, 0);

    // ---------------- bus revoked during SERVICE ----------------
    step();
    chk("rev_hrq", bus.HRQ, 1);
    bus.HLDA = 1'b1;
    step();
    chk("rev_dack", bus.DACK, 4'b0001);
    bus.HLDA = 1'b0;
    step();
    chk("rev_idle", bus.busy, 0);
    chk("rev_end", bus.service_end, 1);
    chk("rev_dack_off", bus.DACK, 4'h0);

    // ---------------- disable during SERVICE ----------------
    step();
    chk("dis_hrq", bus.HRQ, 1);
    bus.HLDA = 1'b1;
    step();
    bus.command = 8'hC4;
    step();
    chk("dis_dack", bus.DACK, 4'b0001);
    chk("dis_busy", bus.busy, 1);
    bus.EOP = 1'b0;
    step();
    chk("dis_end", bus.service_end, 1);
    bus.EOP  = 1'b1;
    bus.HLDA = 1'b0;
    step();
    chk("dis_idle", bus.busy, 0);
    step();
    step();
    chk("dis_no_hrq", bus.HRQ, 0);
    chk("dis_no_busy", bus.busy, 0);
    bus.command = 8'hC0;
    step();
    chk("dis_clear_hrq", bus.HRQ, 1);
    bus.DREQ = 4'b0000;
    step();

    // ---------------- asynchronous reset during SERVICE ----------------
    do_reset();
    bus.DREQ = 4'b1010;
    step();
    chk("ars_ch", bus.active_ch, 1);
    bus.HLDA = 1'b1;
    step();
    chk("ars_dack", bus.DACK, 4'b0010);
    rst = 1'b1;
    #2;
    chk("ars_hrq", bus.HRQ, 0);
    chk("ars_busy", bus.busy, 0);
    chk("ars_dack_off", bus.DACK, 4'h0);
    chk("ars_ch_rst", bus.active_ch, 0);
    bus.HLDA = 1'b0;
    bus.DREQ = 4'b1011;
    step();
    rst = 1'b0;
    step();
    chk("ars_restart_hrq", bus.HRQ, 1);
    chk("ars_restart_ch", bus.active_ch, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Decides which DMA channel owns the system bus, and runs the HRQ/HLDA hold handshake with the CPU.
- Sits between the channel DREQ inputs, the mask register and the command register output on one side, and the address/count/transfer-timing logic on the other.
- Issues one-hot DACK for the granted channel, plus start/end strobes for the per-channel datapath.
- Uses fixed or rotating priority, as selected by the command word.

Parameters:
- NUM_CH, 4, number of DMA channels (2..8).
- CH_W, 2, channel index width; must equal clog2(NUM_CH).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-high reset.
- command  in  8  live command register word. D2=1 disables the controller. D4=1 selects rotating priority, 0 selects fixed. D6=1 means DREQ is active-high, 0 active-low. D7=1 means DACK is active-high, 0 active-low.
- DREQ  in  NUM_CH  channel requests; raw polarity set by command[6].
- mask  in  NUM_CH  1 = channel masked.
- HLDA  in  1  hold acknowledge from the CPU.
- EOP  in  1  end of process, active-low.
- HRQ  out  1  hold request to the CPU.
- DACK  out  NUM_CH  channel acknowledge; polarity set by command[7].
- active_ch  out  CH_W  granted channel index.
- busy  out  1  high in any state other than IDLE.
- service_start  out  1  one-cycle pulse on entry to SERVICE.
- service_end  out  1  one-cycle pulse on exit from SERVICE.

Behaviour:
- Qualified request: qreq[i] = (command[6] ? DREQ[i] : ~DREQ[i]) & ~mask[i]. Combinational from live inputs.
- FSM states: IDLE, REQUEST, SERVICE, RELEASE. State register is reset asynchronously to IDLE.
- IDLE → REQUEST:
  - Condition: command[2]==0 and |qreq.
  - Winner is registered into active_ch; HRQ=1 from the next cycle.
  - Winner is frozen until the state machine is back in IDLE; there is no re-arbitration mid-grant.
- Fixed priority (command[4]==0): channel 0 highest, NUM_CH-1 lowest.
- Rotating priority (command[4]==1):
  - Search order starts at last_ch+1 and wraps modulo NUM_CH.
  - last_ch resets to NUM_CH-1, so channel 0 wins first.
- REQUEST, checked in priority order:
  - HLDA==1 → SERVICE; service_start pulses.
  - Else if qreq[active_ch]==0 → IDLE; HRQ drops; last_ch is unchanged.
  - If HLDA and request-drop occur in the same cycle, HLDA wins.
- SERVICE:
  - HRQ=1 and DACK[active_ch] asserted.
  - Exit on the first of: EOP==0, qreq[active_ch]==0, or HLDA==0.
  - Exit by EOP or request-drop → RELEASE.
  - Exit by HLDA==0 (bus revoked) → IDLE directly.
  - On any exit: service_end pulses, last_ch ← active_ch, and DACK is deasserted in the same edge.
- RELEASE: HRQ=0; stay until HLDA==0, then → IDLE. A new arbitration can start no earlier than the following cycle.
- DACK is combinational from the registered grant vector and the live command[7]. Inactive level is ~command[7] on every bit. Only the bit for active_ch is active, and only while in SERVICE.
- Enable/mode changes mid-operation:
  - Setting command[2]=1 in REQUEST or SERVICE does not abort the grant; it only blocks the next IDLE → REQUEST transition.
  - A change to command[4] takes effect at the next arbitration.
- Mask behaviour: masking the active channel during SERVICE drops qreq, which ends service the same as a request-drop.
- Reset values: HRQ=0, busy=0, service_start=0, service_end=0, active_ch=0, last_ch=NUM_CH-1, grant vector=0. DACK is therefore all ~command[7].
- Reset mid-operation: asserting RESET in any state immediately forces the reset values above, including HRQ=0 and DACK inactive, with no wait for HLDA.
- Latency: DREQ sampled active at edge N → HRQ high after edge N. HLDA sampled at edge M → DACK active and service_start high after edge M.

Test Plan:
- Fixed priority, command=8'hC0, DREQ=4'b1010, mask=0, HLDA returned 2 cycles after HRQ → active_ch=1, DACK=4'b0010, service_start one pulse. EOP low for 1 cycle → service_end pulse, HRQ=0. HLDA dropped → IDLE, then channel 3 is granted.
- Rotating priority, command=8'hD0, DREQ=4'b1111 held, each service ended by EOP → grant order 0,1,2,3,0; active_ch verified per grant.
- Polarity, command=8'h00 (DREQ and DACK active-low): DREQ=4'b1011 → channel 2 granted, DACK=4'b1011 in SERVICE, 4'b1111 otherwise.
- Abort and mask: in REQUEST, drop DREQ[0] with HLDA=0 → back to IDLE, HRQ=0, no service pulses. Separately, mask=4'b0001 with DREQ=4'b0001 → HRQ never rises.
- Disable: command[2]=1 set during SERVICE → service completes normally, no new HRQ afterwards while DREQ stays high. Clearing command[2] → HRQ within 1 cycle.
- Reset: assert RESET in SERVICE → HRQ=0, DACK inactive, busy=0 asynchronously. After release, fixed arbitration restarts with channel 0 highest.
